// File: rtl/i8288_bus_ctrl.sv
// 8288-style bus controller: decodes 8088 S2..S0 into ALE, DEN, DT/R and command strobes.
// Outputs are registered one edge after status sampling; aen_n/cen gate combinationally and never stall the FSM.
module i8288_bus_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] s_n,
  input  logic       aen_n,
  input  logic       cen,
  output logic       ale,
  output logic       den,
  output logic       dt_r_n,
  output logic       mrdc_n,
  output logic       mwtc_n,
  output logic       amwc_n,
  output logic       iorc_n,
  output logic       iowc_n,
  output logic       aiowc_n,
  output logic       inta_n,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_T4   = 3'd4;

  // HALT and passive decode to all-zero: the cycle runs but nothing is strobed.
  typedef struct packed {
    logic mem_rd;
    logic io_rd;
    logic inta;
    logic mem_wr;
    logic io_wr;
  } cyc_t;

  function automatic cyc_t decode(input logic [2:0] s);
    cyc_t c;
    c = '0;
    case (s)
      3'b000:         c.inta   = 1'b1;
      3'b001:         c.io_rd  = 1'b1;
      3'b010:         c.io_wr  = 1'b1;
      3'b100, 3'b101: c.mem_rd = 1'b1;
      3'b110:         c.mem_wr = 1'b1;
      default:        c = '0;
    endcase
    return c;
  endfunction

  logic [2:0] state_q, state_nxt;
  cyc_t       cyc_q, cyc_nxt;
  logic       ale_q, ale_nxt;
  logic       den_q, den_nxt;
  logic       dt_r_n_q, dt_r_n_nxt;
  logic [6:0] cmd_n_q, cmd_n_nxt;
  logic       passive;
  logic       rd_nxt, wr_nxt, in_cmd, in_t3;

  assign passive = &s_n;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE, ST_T4: state_nxt = passive ? ST_IDLE : ST_T1;
      ST_T1:          state_nxt = passive ? ST_T4 : ST_T2;
      ST_T2:          state_nxt = passive ? ST_T4 : ST_T3;
      ST_T3:          state_nxt = passive ? ST_T4 : ST_T3;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  assign cyc_nxt = (state_nxt == ST_T1) ? decode(s_n) : cyc_q;
  assign rd_nxt  = cyc_nxt.mem_rd | cyc_nxt.io_rd | cyc_nxt.inta;
  assign wr_nxt  = cyc_nxt.mem_wr | cyc_nxt.io_wr;
  assign in_cmd  = (state_nxt == ST_T2) || (state_nxt == ST_T3);
  assign in_t3   = (state_nxt == ST_T3);

  always_comb begin
    ale_nxt = (state_nxt == ST_T1);
    den_nxt = (in_cmd & wr_nxt) | (in_t3 & rd_nxt);
    // Direction is held through T4 so the transceivers do not flip before the bus settles.
    case (state_nxt)
      ST_IDLE: dt_r_n_nxt = 1'b1;
      ST_T4:   dt_r_n_nxt = dt_r_n_q;
      default: dt_r_n_nxt = ~rd_nxt;
    endcase
    cmd_n_nxt = {~(in_cmd & cyc_nxt.mem_rd),
                 ~(in_t3  & cyc_nxt.mem_wr),
                 ~(in_cmd & cyc_nxt.mem_wr),
                 ~(in_cmd & cyc_nxt.io_rd),
                 ~(in_t3  & cyc_nxt.io_wr),
                 ~(in_cmd & cyc_nxt.io_wr),
                 ~(in_cmd & cyc_nxt.inta)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      ale_q    <= 1'b0;
      den_q    <= 1'b0;
      dt_r_n_q <= 1'b1;
      cmd_n_q  <= '1;
    end else begin
      state_q  <= state_nxt;
      cyc_q    <= cyc_nxt;
      ale_q    <= ale_nxt;
      den_q    <= den_nxt;
      dt_r_n_q <= dt_r_n_nxt;
      cmd_n_q  <= cmd_n_nxt;
    end
  end

  logic cmd_block;
  assign cmd_block = aen_n | ~cen;

  assign ale     = ale_q;
  assign dt_r_n  = dt_r_n_q;
  assign den     = den_q & cen;
  assign mrdc_n  = cmd_n_q[6] | cmd_block;
  assign mwtc_n  = cmd_n_q[5] | cmd_block;
  assign amwc_n  = cmd_n_q[4] | cmd_block;
  assign iorc_n  = cmd_n_q[3] | cmd_block;
  assign iowc_n  = cmd_n_q[2] | cmd_block;
  assign aiowc_n = cmd_n_q[1] | cmd_block;
  assign inta_n  = cmd_n_q[0] | cmd_block;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i8288_bus_ctrl.sv
// Directed-vector bench for i8288_bus_ctrl; expected words are hand-computed.
// Word layout: {ale,den,dt_r_n}_{mrdc,mwtc,amwc,iorc,iowc,aiowc,inta}_{busy}
module tb_i8288_bus_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] s_n;
  logic       aen_n;
  logic       cen;
  logic       ale, den, dt_r_n, mrdc_n, mwtc_n, amwc_n;
  logic       iorc_n, iowc_n, aiowc_n, inta_n, busy;
  logic [10:0] obs;

  int checks;
  int failures;

  i8288_bus_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_n     (s_n),
    .aen_n   (aen_n),
    .cen     (cen),
    .ale     (ale),
    .den     (den),
    .dt_r_n  (dt_r_n),
    .mrdc_n  (mrdc_n),
    .mwtc_n  (mwtc_n),
    .amwc_n  (amwc_n),
    .iorc_n  (iorc_n),
    .iowc_n  (iowc_n),
    .aiowc_n (aiowc_n),
    .inta_n  (inta_n),
    .busy    (busy)
  );

  assign obs = {ale, den, dt_r_n, mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Present status, let one rising edge sample it, then check just after the edge.
  task automatic cyc(input string tag, input logic [2:0] s, input logic [10:0] exp);
    s_n = s;
    @(posedge clk);
    #1;
    check(tag, obs, exp);
  endtask

  localparam logic [10:0] IDLE_W = 11'b001_1111111_0;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    s_n      = 3'b111;
    aen_n    = 1'b0;
    cen      = 1'b1;
    #12;
    check("reset", obs, IDLE_W);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("idle_passive", 3'b111, IDLE_W);

    // Memory read with one wait state.
    cyc("mrd_t1",   3'b101, 11'b100_1111111_1);
    cyc("mrd_t2",   3'b101, 11'b000_0111111_1);
    cyc("mrd_t3",   3'b101, 11'b010_0111111_1);
    cyc("mrd_t3w",  3'b101, 11'b010_0111111_1);
    cyc("mrd_t4",   3'b111, 11'b000_1111111_1);
    cyc("mrd_idle", 3'b111, IDLE_W);

    // I/O write with two wait states.
    cyc("iow_t1",   3'b010, 11'b101_1111111_1);
    cyc("iow_t2",   3'b010, 11'b011_1111101_1);
    cyc("iow_t3",   3'b010, 11'b011_1111001_1);
    cyc("iow_w1",   3'b010, 11'b011_1111001_1);
    cyc("iow_w2",   3'b010, 11'b011_1111001_1);
    cyc("iow_t4",   3'b111, 11'b001_1111111_1);
    cyc("iow_idle", 3'b111, IDLE_W);

    // Memory write ended early in T2, then back-to-back code fetch.
    cyc("b2b_w_t1", 3'b110, 11'b101_1111111_1);
    cyc("b2b_w_t2", 3'b110, 11'b011_1101111_1);
    cyc("b2b_w_t4", 3'b111, 11'b001_1111111_1);
    cyc("b2b_f_t1", 3'b100, 11'b100_1111111_1);
    cyc("b2b_f_t2", 3'b100, 11'b000_0111111_1);
    cyc("b2b_f_t3", 3'b100, 11'b010_0111111_1);
    cyc("b2b_f_t4", 3'b111, 11'b000_1111111_1);
    cyc("b2b_idle", 3'b111, IDLE_W);

    // HALT: ALE pulse only.
    cyc("halt_t1",   3'b011, 11'b101_1111111_1);
    cyc("halt_t4",   3'b111, 11'b001_1111111_1);
    cyc("halt_idle", 3'b111, IDLE_W);

    // Write aborted in T1: no command ever asserted.
    cyc("wabort_t1", 3'b110, 11'b101_1111111_1);
    cyc("wabort_t4", 3'b111, 11'b001_1111111_1);
    cyc("wabort_id", 3'b111, IDLE_W);

    // INTA with aen_n high, then released combinationally in T3.
    aen_n = 1'b1;
    cyc("inta_t1", 3'b000, 11'b100_1111111_1);
    cyc("inta_t2", 3'b000, 11'b000_1111111_1);
    cyc("inta_t3", 3'b000, 11'b010_1111111_1);
    aen_n = 1'b0;
    #1;
    check("inta_aen_release", obs, 11'b010_1111110_1);
    cyc("inta_t4",   3'b111, 11'b000_1111111_1);
    cyc("inta_idle", 3'b111, IDLE_W);

    // cen dropped mid-read: command and den gated, FSM keeps going.
    cyc("cen_t1", 3'b101, 11'b100_1111111_1);
    cyc("cen_t2", 3'b101, 11'b000_0111111_1);
    cen = 1'b0;
    #1;
    check("cen_low_t2", obs, 11'b000_1111111_1);
    cyc("cen_low_t3", 3'b101, 11'b000_1111111_1);
    cen = 1'b1;
    #1;
    check("cen_high_t3", obs, 11'b010_0111111_1);
    cyc("cen_t4",   3'b111, 11'b000_1111111_1);
    cyc("cen_idle", 3'b111, IDLE_W);

    // Reset asserted in T3 of a memory write.
    cyc("rst_w_t1", 3'b110, 11'b101_1111111_1);
    cyc("rst_w_t2", 3'b110, 11'b011_1101111_1);
    cyc("rst_w_t3", 3'b110, 11'b011_1001111_1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_write", obs, IDLE_W);
    s_n = 3'b111;
    #2;
    rst_n = 1'b1;
    cyc("rst_post1", 3'b111, IDLE_W);
    cyc("rst_post2", 3'b111, IDLE_W);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
